pulse_measure: RTL and testbench

//  Receive-side counterpart of the countdown timer. Measures the width, in clk cycles, of

---
 rtl/timer_pkg.sv | 14 +
 rtl/sat_counter.sv | 44 ++++
 rtl/pulse_measure.sv | 124 ++++++++++++
 tb/tb_pulse_measure.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and its receive-side pulse_measure.
//  TIMER_WIDTH : common count width of the timer cycles port and the measured result
//  pm_state_t  : pulse_measure FSM states
package timer_pkg;

   localparam int unsigned TIMER_WIDTH = 16;

   typedef enum logic [1:0] {
      ARM   = 2'd0,
      IDLE  = 2'd1,
      COUNT = 2'd2
   } pm_state_t;

endpackage : timer_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk, reset : clock and synchronous active-high reset
//  clr        : clear to zero (wins over inc)
//  inc        : increment by one, holding at all-ones
//  q          : current count
//  sat        : count is at its maximum
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next count: clear, saturating increment or hold.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != MAX)) begin
         q_d = q_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q   = q_q;
   assign sat = (q_q == MAX);

endmodule : sat_counter

// File: rtl/pulse_measure.sv
// Measures the width in clk cycles of each high pulse on pulse_in and offers the
// result through a one-entry valid/ready output register.
//  clk, reset : clock and synchronous active-high reset
//  pulse_in   : pulse to measure, already synchronous to clk
//  ready      : consumer accepts the held result when valid && ready
//  valid      : measured/overflow hold a result
//  measured   : width of the last completed pulse
//  overflow   : that pulse saturated the counter (>= 2^WIDTH-1 cycles)
//  busy       : a pulse is being counted
//  dropped    : one-cycle strobe, a completed result was discarded on overrun
module pulse_measure
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse_in,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] measured,
   output logic             overflow,
   output logic             busy,
   output logic             dropped
);

   pm_state_t        state_q, state_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] measured_q, measured_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             dropped_q, dropped_d;

   logic             complete;
   logic             cnt_clr;
   logic             cnt_inc;
   logic [WIDTH-1:0] count;
   logic             cnt_sat;

   sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .q     (count),
      .sat   (cnt_sat)
   );

   // Next state, counter control and output register update.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      measured_d = measured_q;
      overflow_d = overflow_q;
      dropped_d  = 1'b0;
      complete   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;

      case (state_q)
         // Wait for a low sample so a pulse already high out of reset is ignored.
         ARM: begin
            if (!pulse_in) state_d = IDLE;
         end
         // Counter is zero here, so the first high sample counts to 1.
         IDLE: begin
            if (pulse_in) begin
               state_d = COUNT;
               cnt_inc = 1'b1;
            end
         end
         COUNT: begin
            if (pulse_in) begin
               cnt_inc = 1'b1;
            end else begin
               state_d  = IDLE;
               complete = 1'b1;
               cnt_clr  = 1'b1;
            end
         end
         default: begin
            state_d = ARM;
            cnt_clr = 1'b1;
         end
      endcase

      // The entry is free if empty or being accepted on this same edge.
      if (complete && (!valid_q || ready)) begin
         valid_d    = 1'b1;
         measured_d = count;
         overflow_d = cnt_sat;
      end else begin
         if (complete) dropped_d = 1'b1;
         if (valid_q && ready) valid_d = 1'b0;
      end

      busy_d = (state_d == COUNT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARM;
         valid_q    <= 1'b0;
         measured_q <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         measured_q <= measured_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
      end
   end

   assign valid    = valid_q;
   assign measured = measured_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign dropped  = dropped_q;

endmodule : pulse_measure

// File: tb/tb_pulse_measure.sv
// Self-checking bench for pulse_measure: a 16-bit instance for the main scenarios
// and a 4-bit instance for saturation. Expected results are queued when a pulse is
// driven and compared when the DUT hands a result over (valid && ready).
module tb_pulse_measure;

   logic        clk;
   logic        reset;
   logic        pulse_in;
   logic        ready;
   logic        valid;
   logic [15:0] measured;
   logic        overflow;
   logic        busy;
   logic        dropped;

   logic        pulse4;
   logic        ready4;
   logic        valid4;
   logic [3:0]  measured4;
   logic        overflow4;
   logic        busy4;
   logic        dropped4;

   int          checks;
   int          failures;
   int          drop_cnt;
   int          drop4_cnt;
   int          busy_cnt;

   logic [16:0] exp_q[$];   // {measured, overflow} for the 16-bit instance
   logic [4:0]  exp4_q[$];  // {measured, overflow} for the 4-bit instance

   pulse_measure #(.WIDTH(16)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .pulse_in (pulse_in),
      .ready    (ready),
      .valid    (valid),
      .measured (measured),
      .overflow (overflow),
      .busy     (busy),
      .dropped  (dropped)
   );

   pulse_measure #(.WIDTH(4)) u_dut4 (
      .clk      (clk),
      .reset    (reset),
      .pulse_in (pulse4),
      .ready    (ready4),
      .valid    (valid4),
      .measured (measured4),
      .overflow (overflow4),
      .busy     (busy4),
      .dropped  (dropped4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold pulse_in high for n sampling edges, then drop it; counts busy samples.
   task automatic drive_pulse(input int n);
      pulse_in = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (busy) busy_cnt++;
      end
      pulse_in = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp4_q.size() != 0 || valid || valid4) && n < 200) begin
         tick();
         n++;
      end
      check("drain_timeout", 32'(n < 200), 32'd1);
   endtask

   // Scoreboard: compare each result at the edge where it is accepted.
   always @(negedge clk) begin
      logic [16:0] e;
      logic [4:0]  e4;
      if (!reset) begin
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("measured", 32'(measured), 32'(e[16:1]));
               check("overflow", 32'(overflow), 32'(e[0]));
            end
         end
         if (valid4 && ready4) begin
            if (exp4_q.size() == 0) begin
               check("unexpected_result4", 32'(exp4_q.size()), 32'd1);
            end else begin
               e4 = exp4_q.pop_front();
               check("measured4", 32'(measured4), 32'(e4[4:1]));
               check("overflow4", 32'(overflow4), 32'(e4[0]));
            end
         end
         if (dropped)  drop_cnt++;
         if (dropped4) drop4_cnt++;
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      drop_cnt  = 0;
      drop4_cnt = 0;
      busy_cnt  = 0;
      reset     = 1'b1;
      pulse_in  = 1'b0;
      ready     = 1'b0;
      pulse4    = 1'b0;
      ready4    = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_valid",    32'(valid),    32'd0);
      check("rst_measured", 32'(measured), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_dropped",  32'(dropped),  32'd0);
      reset = 1'b0;
      tick();
      tick();

      // 1: 5-cycle pulse, result one cycle after the first low edge
      exp_q.push_back({16'd5, 1'b0});
      drive_pulse(5);
      check("t1_busy_cycles", 32'(busy_cnt), 32'd5);
      check("t1_valid_early", 32'(valid), 32'd0);
      tick();
      check("t1_valid",    32'(valid),    32'd1);
      check("t1_measured", 32'(measured), 32'd5);
      check("t1_busy_end", 32'(busy),     32'd0);
      ready = 1'b1;
      drain();

      // 2: timer loop-back style loads 3, 1, 1000 with held results
      ready = 1'b0;
      exp_q.push_back({16'd3, 1'b0});
      drive_pulse(3);
      repeat (4) tick();
      check("t2_hold_valid", 32'(valid),    32'd1);
      check("t2_hold_meas",  32'(measured), 32'd3);
      ready = 1'b1;
      drain();
      exp_q.push_back({16'd1, 1'b0});
      drive_pulse(1);
      tick();
      exp_q.push_back({16'd1000, 1'b0});
      drive_pulse(1000);
      drain();
      check("t2_no_drop", 32'(drop_cnt), 32'd0);

      // 3: reset mid-pulse, pulse still high after release is ignored
      pulse_in = 1'b1;
      reset    = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      repeat (4) tick();
      pulse_in = 1'b0;
      tick();
      tick();
      check("t3_no_valid", 32'(valid), 32'd0);
      check("t3_no_busy",  32'(busy),  32'd0);
      exp_q.push_back({16'd2, 1'b0});
      drive_pulse(2);
      drain();

      // 4: overrun while ready is low
      ready = 1'b0;
      exp_q.push_back({16'd7, 1'b0});
      drive_pulse(7);
      tick();
      drive_pulse(9);
      tick();
      check("t4_dropped",  32'(dropped),  32'd1);
      check("t4_held",     32'(measured), 32'd7);
      check("t4_valid",    32'(valid),    32'd1);
      tick();
      check("t4_drop_one", 32'(dropped),  32'd0);
      ready = 1'b1;
      tick();
      tick();
      check("t4_valid_off", 32'(valid), 32'd0);
      drain();
      check("t4_drop_cnt", 32'(drop_cnt), 32'd1);

      // Accept and complete on the same edge: no drop, valid stays high
      ready = 1'b0;
      exp_q.push_back({16'd3, 1'b0});
      drive_pulse(3);
      tick();
      exp_q.push_back({16'd4, 1'b0});
      drive_pulse(4);
      ready = 1'b1;
      tick();
      check("same_edge_valid", 32'(valid),    32'd1);
      check("same_edge_meas",  32'(measured), 32'd4);
      check("same_edge_drop",  32'(dropped),  32'd0);
      drain();

      // 5: back-to-back 2, 1, 2 with single low gaps, ready always high
      exp_q.push_back({16'd2, 1'b0});
      drive_pulse(2);
      tick();
      exp_q.push_back({16'd1, 1'b0});
      drive_pulse(1);
      tick();
      exp_q.push_back({16'd2, 1'b0});
      drive_pulse(2);
      tick();
      drain();
      check("t5_drop_cnt", 32'(drop_cnt), 32'd1);

      // 6: 4-bit instance saturates at 15
      exp4_q.push_back({4'd15, 1'b1});
      pulse4 = 1'b1;
      repeat (20) tick();
      pulse4 = 1'b0;
      tick();
      exp4_q.push_back({4'd3, 1'b0});
      pulse4 = 1'b1;
      repeat (3) tick();
      pulse4 = 1'b0;
      tick();
      drain();
      check("t6_drop4_cnt", 32'(drop4_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pulse_measure
